// File: rtl/seg7_mux_sniffer_if.sv
// Bundle for the multiplexed 7-segment receive side: raw display lines in,
// reconstructed two-digit value out.
interface seg7_mux_sniffer_if;
  logic [7:0] seg_in;
  logic [1:0] com_in;
  logic       seg_pol;
  logic       com_pol;
  logic [3:0] digit1;
  logic [3:0] digit10;
  logic       digit10_blank;
  logic [6:0] value_bin;
  logic       valid;
  logic       update;
  logic       seg_err;

  modport master (
    output seg_in, com_in, seg_pol, com_pol,
    input  digit1, digit10, digit10_blank, value_bin, valid, update, seg_err
  );

  modport slave (
    input  seg_in, com_in, seg_pol, com_pol,
    output digit1, digit10, digit10_blank, value_bin, valid, update, seg_err
  );
endinterface

// File: rtl/seg7_mux_sniffer.sv
// Sniffs a two-digit multiplexed 7-segment display and rebuilds the shown
// value (0..99) with per-digit stability filtering and blank/idle detection.
module seg7_mux_sniffer #(
  parameter int unsigned STABLE_CNT   = 4,
  parameter int unsigned TENS_TIMEOUT = 256,
  parameter int unsigned IDLE_TIMEOUT = 4096
) (
  input logic               clk,
  input logic               rst,
  seg7_mux_sniffer_if.slave bus
);
  localparam int unsigned SW = $clog2(STABLE_CNT + 1);
  localparam int unsigned GW = $clog2(TENS_TIMEOUT + 1);
  localparam int unsigned IW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CNT);
  localparam logic [GW-1:0] GAP_MAX  = GW'(TENS_TIMEOUT);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_TIMEOUT);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACQUIRE = 2'd1, S_LOCKED = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [6:0]    seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d;
  logic [1:0]    com_s1_q, com_s1_d, com_s2_q, com_s2_d;
  logic [1:0]    pol_s1_q, pol_s1_d, pol_s2_q, pol_s2_d;
  logic [6:0]    last_u_q, last_u_d, last_t_q, last_t_d;
  logic [SW-1:0] stab_u_q, stab_u_d, stab_t_q, stab_t_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [3:0]    digit1_q, digit1_d, digit10_q, digit10_d;
  logic [6:0]    value_q, value_d;
  logic          blank_q, blank_d, seg_err_q, seg_err_d;
  logic          valid_q, valid_d, valid_dly_q, valid_dly_d, update_q, update_d;

  logic [6:0] seg_n;
  logic [1:0] com_n;
  logic [4:0] dec;
  logic       smp_u, smp_t, commit_u, commit_t, idle_to, blank_evt;

  // {valid, bcd}; several digits have two accepted segment renderings
  function automatic logic [4:0] decode(input logic [6:0] c);
    case (c)
      7'h3F:        decode = {1'b1, 4'd0};
      7'h06:        decode = {1'b1, 4'd1};
      7'h5B:        decode = {1'b1, 4'd2};
      7'h4F:        decode = {1'b1, 4'd3};
      7'h66:        decode = {1'b1, 4'd4};
      7'h6D:        decode = {1'b1, 4'd5};
      7'h7D, 7'h7C: decode = {1'b1, 4'd6};
      7'h07, 7'h27: decode = {1'b1, 4'd7};
      7'h7F:        decode = {1'b1, 4'd8};
      7'h6F, 7'h67: decode = {1'b1, 4'd9};
      default:      decode = 5'b0_0000;
    endcase
  endfunction

  always_comb begin
    seg_s1_d = bus.seg_in[6:0];
    seg_s2_d = seg_s1_q;
    com_s1_d = bus.com_in;
    com_s2_d = com_s1_q;
    pol_s1_d = {bus.seg_pol, bus.com_pol};
    pol_s2_d = pol_s1_q;

    seg_n = seg_s2_q ^ {7{~pol_s2_q[1]}};
    com_n = com_s2_q ^ {2{~pol_s2_q[0]}};
    smp_u = (com_n == 2'b01);
    smp_t = (com_n == 2'b10);
    dec   = decode(seg_n);

    idle_d = idle_q;
    if (com_n != 2'b00)        idle_d = '0;
    else if (idle_q != IDLE_MAX) idle_d = idle_q + 1'b1;
    idle_to = (state_q != S_IDLE) && (idle_d == IDLE_MAX);

    last_u_d = last_u_q;
    stab_u_d = stab_u_q;
    if (smp_u) begin
      if (seg_n != last_u_q) begin
        last_u_d = seg_n;
        stab_u_d = SW'(1);
      end else if (stab_u_q != STAB_MAX) begin
        stab_u_d = stab_u_q + 1'b1;
      end
    end
    last_t_d = last_t_q;
    stab_t_d = stab_t_q;
    if (smp_t) begin
      if (seg_n != last_t_q) begin
        last_t_d = seg_n;
        stab_t_d = SW'(1);
      end else if (stab_t_q != STAB_MAX) begin
        stab_t_d = stab_t_q + 1'b1;
      end
    end
    // commit only on the sample that lands the counter on its saturation value
    commit_u = smp_u && !idle_to && (stab_u_q != STAB_MAX) && (stab_u_d == STAB_MAX);
    commit_t = smp_t && !idle_to && (stab_t_q != STAB_MAX) && (stab_t_d == STAB_MAX);

    gap_d = gap_q;
    if (smp_t)                          gap_d = '0;
    else if (smp_u && gap_q != GAP_MAX) gap_d = gap_q + 1'b1;
    blank_evt = (gap_q != GAP_MAX) && (gap_d == GAP_MAX);

    digit1_d  = digit1_q;
    digit10_d = digit10_q;
    blank_d   = blank_q;
    seg_err_d = seg_err_q;
    if (commit_u) begin
      if (dec[4]) digit1_d = dec[3:0];
      else        seg_err_d = 1'b1;
    end
    if (commit_t) begin
      if (dec[4]) begin
        digit10_d = dec[3:0];
        blank_d   = 1'b0;
      end else begin
        seg_err_d = 1'b1;
      end
    end else if (blank_evt) begin
      digit10_d = '0;
      blank_d   = 1'b1;
    end

    state_d = state_q;
    case (state_q)
      S_IDLE:    if (smp_u || smp_t) state_d = S_ACQUIRE;
      S_ACQUIRE: if (commit_u)       state_d = S_LOCKED;
      default:   state_d = state_q;
    endcase
    if (idle_to) begin
      state_d  = S_IDLE;
      stab_u_d = '0;
      stab_t_d = '0;
      gap_d    = '0;
    end

    valid_d     = (state_d == S_LOCKED);
    value_d     = ({3'b000, digit10_q} * 7'd10) + {3'b000, digit1_q};
    valid_dly_d = valid_q;
    update_d    = valid_q && ((value_d != value_q) || !valid_dly_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      seg_s1_q    <= '0;
      seg_s2_q    <= '0;
      com_s1_q    <= '0;
      com_s2_q    <= '0;
      pol_s1_q    <= '0;
      pol_s2_q    <= '0;
      last_u_q    <= '0;
      last_t_q    <= '0;
      stab_u_q    <= '0;
      stab_t_q    <= '0;
      gap_q       <= '0;
      idle_q      <= '0;
      digit1_q    <= '0;
      digit10_q   <= '0;
      value_q     <= '0;
      blank_q     <= 1'b0;
      seg_err_q   <= 1'b0;
      valid_q     <= 1'b0;
      valid_dly_q <= 1'b0;
      update_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      seg_s1_q    <= seg_s1_d;
      seg_s2_q    <= seg_s2_d;
      com_s1_q    <= com_s1_d;
      com_s2_q    <= com_s2_d;
      pol_s1_q    <= pol_s1_d;
      pol_s2_q    <= pol_s2_d;
      last_u_q    <= last_u_d;
      last_t_q    <= last_t_d;
      stab_u_q    <= stab_u_d;
      stab_t_q    <= stab_t_d;
      gap_q       <= gap_d;
      idle_q      <= idle_d;
      digit1_q    <= digit1_d;
      digit10_q   <= digit10_d;
      value_q     <= value_d;
      blank_q     <= blank_d;
      seg_err_q   <= seg_err_d;
      valid_q     <= valid_d;
      valid_dly_q <= valid_dly_d;
      update_q    <= update_d;
    end
  end

  assign bus.digit1        = digit1_q;
  assign bus.digit10       = digit10_q;
  assign bus.digit10_blank = blank_q;
  assign bus.value_bin     = value_q;
  assign bus.valid         = valid_q;
  assign bus.update        = update_q;
  assign bus.seg_err       = seg_err_q;
endmodule

// File: tb/tb_seg7_mux_sniffer.sv
// Self-checking bench: directed display scenarios plus a randomized display
// stream compared cycle by cycle against a sample-level reference model.
module tb_seg7_mux_sniffer;
  localparam int unsigned SC = 4;
  localparam int unsigned TT = 256;
  localparam int unsigned IT = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_mux_sniffer_if bus ();

  seg7_mux_sniffer #(.STABLE_CNT(SC), .TENS_TIMEOUT(TT), .IDLE_TIMEOUT(IT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [7:0] seg;
    logic [1:0] com;
    logic       sp;
    logic       cp;
  } in_t;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_upd    = 0;
  bit          spol = 1'b1;
  bit          cpol = 1'b1;
  logic [6:0]  codes [13] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D,
                              7'h7C, 7'h07, 7'h27, 7'h7F, 7'h6F, 7'h67};

  // reference model: what the display meant, tracked per sample
  in_t pipe [$];
  int  dec_tab [128];
  int  m_last [2];
  int  m_stab [2];
  int  m_gap, m_idle, m_state, m_d1, m_d10, m_value;
  bit  m_blank, m_err, m_valid, m_valid_prev, m_update;

  function automatic void model_reset();
    in_t z;
    z = '0;
    pipe.delete();
    pipe.push_back(z);
    pipe.push_back(z);
    m_last = '{0, 0};
    m_stab = '{0, 0};
    m_gap = 0; m_idle = 0; m_state = 0; m_d1 = 0; m_d10 = 0; m_value = 0;
    m_blank = 0; m_err = 0; m_valid = 0; m_valid_prev = 0; m_update = 0;
  endfunction

  function automatic void model_tick();
    in_t cur, x;
    int  s, c, ch, v, st0;
    bit  to, commit;
    cur.seg = bus.seg_in;
    cur.com = bus.com_in;
    cur.sp  = bus.seg_pol;
    cur.cp  = bus.com_pol;
    pipe.push_back(cur);
    x = pipe.pop_front();
    s = int'(x.seg[6:0] ^ (x.sp ? 7'h00 : 7'h7F));
    c = int'(x.com ^ (x.cp ? 2'b00 : 2'b11));
    v = m_d10 * 10 + m_d1;
    m_update     = m_valid && ((v != m_value) || !m_valid_prev);
    m_valid_prev = m_valid;
    m_value      = v;
    ch = (c == 1) ? 0 : (c == 2) ? 1 : -1;
    m_idle = (c != 0) ? 0 : ((m_idle < IT) ? m_idle + 1 : IT);
    to = (m_state != 0) && (m_idle == IT);
    commit = 0;
    st0 = m_state;
    if (to) begin
      m_state = 0;
      m_stab  = '{0, 0};
      m_gap   = 0;
    end else if (ch >= 0) begin
      if (s == m_last[ch]) begin
        if (m_stab[ch] < SC) begin
          m_stab[ch]++;
          commit = (m_stab[ch] == SC);
        end
      end else begin
        m_last[ch] = s;
        m_stab[ch] = 1;
      end
      if (commit) begin
        if (dec_tab[s] < 0) m_err = 1;
        else if (ch == 0) m_d1 = dec_tab[s];
        else begin
          m_d10   = dec_tab[s];
          m_blank = 0;
        end
      end
      if (st0 == 0) m_state = 1;
      else if (st0 == 1 && commit && ch == 0) m_state = 2;
      if (ch == 1) m_gap = 0;
      else if (m_gap < TT) begin
        m_gap++;
        if (m_gap == TT) begin
          m_d10   = 0;
          m_blank = 1;
        end
      end
    end
    m_valid = (m_state == 2);
  endfunction

  function automatic logic [18:0] pack(input int d1, input int d10, input bit bl,
                                       input int v, input bit va, input bit up, input bit er);
    return {4'(d1), 4'(d10), bl, 7'(v), va, up, er};
  endfunction

  function automatic logic [18:0] obs();
    return {bus.digit1, bus.digit10, bus.digit10_blank, bus.value_bin,
            bus.valid, bus.update, bus.seg_err};
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_tick();
    #1;
    if (bus.update === 1'b1) n_upd++;
  endtask

  task automatic set_in(input logic [6:0] code, input logic [1:0] com);
    logic dp;
    dp = 1'($urandom_range(0, 1));
    bus.seg_in  = spol ? {dp, code} : ~{dp, code};
    bus.com_in  = cpol ? com : ~com;
    bus.seg_pol = spol;
    bus.com_pol = cpol;
  endtask

  task automatic put(input logic [6:0] code, input logic [1:0] com, input int unsigned n);
    set_in(code, com);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    n_upd = 0;
  endtask

  // tens burst first, then units, 4 clocks each
  task automatic play_27(input int unsigned n);
    repeat (n) begin
      put(7'h5B, 2'b10, 4);
      put(7'h07, 2'b01, 4);
    end
  endtask

  task automatic test_reset();
    logic [18:0] e;
    spol = 1; cpol = 1;
    set_in(7'h00, 2'b00);
    do_reset();
    n_checks++;
    if (obs() !== 19'h0) begin n_fail++; $display("FAIL reset_initial: got %h exp %h", obs(), 19'h0); end
    play_27(6);
    e = pack(7, 2, 0, 27, 1, 0, 0);
    n_checks++;
    if (obs() !== e) begin n_fail++; $display("FAIL reset_prelock: got %h exp %h", obs(), e); end
    rst = 1'b1;
    n_upd = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (obs() !== 19'h0) begin n_fail++; $display("FAIL reset_held[%0d]: got %h exp %h", i, obs(), 19'h0); end
    end
    rst = 1'b0;
    put(7'h00, 2'b00, 5);
    n_checks++;
    if (obs() !== 19'h0) begin n_fail++; $display("FAIL reset_after: got %h exp %h", obs(), 19'h0); end
    n_checks++;
    if (n_upd != 0) begin n_fail++; $display("FAIL reset_no_update: got %0d exp 0", n_upd); end
  endtask

  task automatic test_lock(input bit pol, input string tag);
    logic [18:0] e;
    spol = pol; cpol = pol;
    set_in(7'h00, 2'b00);
    do_reset();
    play_27(8);
    e = pack(7, 2, 0, 27, 1, 0, 0);
    n_checks++;
    if (obs() !== e) begin n_fail++; $display("FAIL %s_outputs: got %h exp %h", tag, obs(), e); end
    n_checks++;
    if (n_upd != 1) begin n_fail++; $display("FAIL %s_update_count: got %0d exp 1", tag, n_upd); end
  endtask

  task automatic test_tens_blank();
    logic [18:0] e;
    spol = 1; cpol = 1;
    do_reset();
    put(7'h6D, 2'b01, 257);
    n_checks++;
    if (bus.digit10_blank !== 1'b0) begin n_fail++; $display("FAIL blank_early: got %b exp 0", bus.digit10_blank); end
    step();
    n_checks++;
    if (bus.digit10_blank !== 1'b1) begin n_fail++; $display("FAIL blank_edge: got %b exp 1", bus.digit10_blank); end
    repeat (42) step();
    e = pack(5, 0, 1, 5, 1, 0, 0);
    n_checks++;
    if (obs() !== e) begin n_fail++; $display("FAIL blank_outputs: got %h exp %h", obs(), e); end
  endtask

  task automatic test_glitch();
    logic [18:0] e;
    spol = 1; cpol = 1;
    do_reset();
    play_27(4);
    n_upd = 0;
    put(7'h5B, 2'b10, 4);
    put(7'h07, 2'b01, 1);
    put(7'h7F, 2'b01, 1);
    put(7'h07, 2'b01, 2);
    put(7'h5B, 2'b10, 4);
    n_checks++;
    if (bus.value_bin !== 7'd27) begin n_fail++; $display("FAIL glitch_midway: got %0d exp 27", bus.value_bin); end
    play_27(3);
    e = pack(7, 2, 0, 27, 1, 0, 0);
    n_checks++;
    if (obs() !== e) begin n_fail++; $display("FAIL glitch_outputs: got %h exp %h", obs(), e); end
    n_checks++;
    if (n_upd != 0) begin n_fail++; $display("FAIL glitch_no_update: got %0d exp 0", n_upd); end
  endtask

  task automatic test_seg_err_idle();
    logic [18:0] e;
    put(7'h49, 2'b01, 10);
    e = pack(7, 2, 0, 27, 1, 0, 1);
    n_checks++;
    if (obs() !== e) begin n_fail++; $display("FAIL seg_err_outputs: got %h exp %h", obs(), e); end
    put(7'h00, 2'b00, 4097);
    n_checks++;
    if (bus.valid !== 1'b1) begin n_fail++; $display("FAIL idle_before_timeout: got %b exp 1", bus.valid); end
    step();
    e = pack(7, 2, 0, 27, 0, 0, 1);
    n_checks++;
    if (obs() !== e) begin n_fail++; $display("FAIL idle_timeout: got %h exp %h", obs(), e); end
  endtask

  task automatic test_random();
    logic [18:0]  e;
    logic [6:0]   code_u, code_t, code;
    logic [1:0]   com;
    int unsigned  r, len;
    spol = 1; cpol = 0;
    do_reset();
    code_u = codes[$urandom_range(0, 12)];
    code_t = codes[$urandom_range(0, 12)];
    for (int unsigned b = 0; b < 600; b++) begin
      if ($urandom_range(0, 49) == 0) begin
        spol = 1'($urandom_range(0, 1));
        cpol = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 7) == 0) code_u = ($urandom_range(0, 4) == 0) ? 7'($urandom) : codes[$urandom_range(0, 12)];
      if ($urandom_range(0, 7) == 0) code_t = ($urandom_range(0, 4) == 0) ? 7'($urandom) : codes[$urandom_range(0, 12)];
      r = $urandom_range(0, 9);
      com = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b00 : 2'b11;
      code = (com == 2'b10) ? code_t : code_u;
      len = $urandom_range(1, 6);
      if ($urandom_range(0, 99) == 0) begin
        com  = 2'b01;
        code = code_u;
        len  = 280;
      end
      rst = ($urandom_range(0, 199) == 0);
      set_in(code, com);
      for (int unsigned i = 0; i < len; i++) begin
        step();
        rst = 1'b0;
        e = pack(m_d1, m_d10, m_blank, m_value, m_valid, m_update, m_err);
        n_checks++;
        if (obs() !== e) begin
          n_fail++;
          $display("FAIL random_b%0d_c%0d: got %h exp %h", b, i, obs(), e);
        end
      end
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) dec_tab[i] = -1;
    dec_tab['h3F] = 0; dec_tab['h06] = 1; dec_tab['h5B] = 2; dec_tab['h4F] = 3;
    dec_tab['h66] = 4; dec_tab['h6D] = 5; dec_tab['h7D] = 6; dec_tab['h7C] = 6;
    dec_tab['h07] = 7; dec_tab['h27] = 7; dec_tab['h7F] = 8; dec_tab['h6F] = 9;
    dec_tab['h67] = 9;
    model_reset();
    test_reset();
    test_lock(1'b1, "lock_pos");
    test_lock(1'b0, "lock_neg");
    test_tens_blank();
    test_glitch();
    test_seg_err_idle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
